// File: rtl/video_timing_gen.sv
// Video timing generator: h/v counters, syncs, active video, SOF and a windowed pixel request/address.
// Define VTG_TEST_PATTERN_EN to drive an 8-bar colour test pattern on pat_rgb_o.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int WIN_W    = 225,
  parameter int WIN_H    = 225,
  parameter int CNT_W    = 12,
  parameter int ADDR_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [CNT_W-1:0]  win_x_i,
  input  logic [CNT_W-1:0]  win_y_i,
  output logic              hs_o,
  output logic              vs_o,
  output logic              de_o,
  output logic [CNT_W-1:0]  cnt_h_o,
  output logic [CNT_W-1:0]  cnt_v_o,
  output logic              sof_o,
  output logic              win_req_o,
  output logic [ADDR_W-1:0] win_addr_o,
  output logic [23:0]       pat_rgb_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W:0]   WIN_W_C  = (CNT_W+1)'(WIN_W);
  localparam logic [CNT_W:0]   WIN_H_C  = (CNT_W+1)'(WIN_H);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIN_W);

  logic [CNT_W-1:0]  h, v, wx, wy, col_off;
  logic [ADDR_W-1:0] row_base, addr;
  logic              h_last, v_last, active, in_col, in_row, req, hs_n, vs_n;

  always_comb begin
    h_last  = (h == H_LAST);
    v_last  = (v == V_LAST);
    active  = (h < H_ACT) && (v < V_ACT);
    // Window ends compared one bit wider so origins near the top of the range cannot wrap
    in_col  = (h >= wx) && ({1'b0, h} < ({1'b0, wx} + WIN_W_C));
    in_row  = (v >= wy) && ({1'b0, v} < ({1'b0, wy} + WIN_H_C));
    req     = active && in_col && in_row;
    col_off = h - wx;
    addr    = req ? (row_base + ADDR_W'(col_off)) : '0;
    hs_n    = ((h >= HS_BEG) && (h < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vs_n    = ((v >= VS_BEG) && (v < VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h          <= '0;
      v          <= '0;
      wx         <= '0;
      wy         <= '0;
      row_base   <= '0;
      hs_o       <= ~SYNC_POL;
      vs_o       <= ~SYNC_POL;
      de_o       <= 1'b0;
      sof_o      <= 1'b0;
      win_req_o  <= 1'b0;
      win_addr_o <= '0;
      cnt_h_o    <= '0;
      cnt_v_o    <= '0;
    end else if (en_i) begin
      h <= h_last ? '0 : h + CNT_W'(1);
      if (h_last) begin
        v <= v_last ? '0 : v + CNT_W'(1);
        // Row base is the address of column wx on the next line: step it after each window line
        if (v_last)      row_base <= '0;
        else if (in_row) row_base <= row_base + ROW_STEP;
      end
      if (h_last && v_last) begin
        wx <= win_x_i;
        wy <= win_y_i;
      end
      hs_o       <= hs_n;
      vs_o       <= vs_n;
      de_o       <= active;
      sof_o      <= (h == '0) && (v == '0);
      win_req_o  <= req;
      win_addr_o <= addr;
      cnt_h_o    <= h;
      cnt_v_o    <= v;
    end else begin
      de_o       <= 1'b0;
      sof_o      <= 1'b0;
      win_req_o  <= 1'b0;
      win_addr_o <= '0;
    end
  end

`ifdef VTG_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [2:0]  bar;
  logic [23:0] pat_n;

  // Bar index bits map straight to inverted channels: bit1->r, bit2->g, bit0->b
  always_comb begin
    bar = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (h >= CNT_W'(i * BAR_W)) bar = 3'(i);
    end
    pat_n = active ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     pat_rgb_o <= '0;
    else if (en_i) pat_rgb_o <= pat_n;
    else           pat_rgb_o <= '0;
  end
`else
  assign pat_rgb_o = '0;
`endif

endmodule
